// File: rtl/trace_buffer.sv
// Circular FIFO capturing the TinyRV1 commit trace and draining it over a val/rdy port.
// Optional macro TRACE_BUFFER_TIMESTAMP_EN adds a per-entry cycle stamp and the deq_cycle output.
module trace_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             trace_val,
    input  logic [31:0]      trace_addr,
    input  logic [31:0]      trace_data,
    output logic             deq_val,
    input  logic             deq_rdy,
    output logic [31:0]      deq_addr,
    output logic [31:0]      deq_data,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic [15:0]      drop_count
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    ,
    output logic [31:0]      deq_cycle
`endif
);

    localparam logic [PTR_W-1:0] L_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] L_PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   L_CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   L_CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [15:0]      L_DROP_MAX = 16'hFFFF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
        logic [31:0] cycle;
`endif
    } entry_t;

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == L_PTR_LAST) ? '0 : p + L_PTR_ONE;
    endfunction

    // State registers
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic [15:0]      r_drop_count;
    entry_t           r_mem [DEPTH];

    // Next-state and control wires
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W:0]   w_count_nxt;
    logic             w_overflow_nxt;
    logic [15:0]      w_drop_count_nxt;
    logic             w_empty;
    logic             w_full;
    logic             w_deq_fire;
    logic             w_enq;
    logic             w_drop;
    logic             w_mem_we;
    entry_t           w_wr_entry;
    entry_t           w_head;

`ifdef TRACE_BUFFER_TIMESTAMP_EN
    logic [31:0] r_cycle;

    // Free-running stamp source; deliberately immune to clear so stamps stay monotonic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`endif

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == L_CNT_FULL);
    assign w_deq_fire = !w_empty && deq_rdy;
    // A full buffer still accepts a trace when the head leaves in the same cycle.
    assign w_enq      = trace_val && (!w_full || w_deq_fire);
    assign w_drop     = trace_val && w_full && !w_deq_fire;
    assign w_mem_we   = w_enq && !clear;

    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.addr = trace_addr;
        w_wr_entry.data = trace_data;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
        w_wr_entry.cycle = r_cycle;
`endif
    end

    always_comb begin
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_count_nxt      = r_count;
        w_overflow_nxt   = r_overflow;
        w_drop_count_nxt = r_drop_count;

        if (clear) begin
            w_wr_ptr_nxt     = '0;
            w_rd_ptr_nxt     = '0;
            w_count_nxt      = '0;
            w_overflow_nxt   = 1'b0;
            w_drop_count_nxt = '0;
        end else begin
            if (w_enq) begin
                w_wr_ptr_nxt = f_ptr_inc(r_wr_ptr);
            end
            if (w_deq_fire) begin
                w_rd_ptr_nxt = f_ptr_inc(r_rd_ptr);
            end

            case ({w_enq, w_deq_fire})
                2'b10:   w_count_nxt = r_count + L_CNT_ONE;
                2'b01:   w_count_nxt = r_count - L_CNT_ONE;
                default: w_count_nxt = r_count;
            endcase

            if (w_drop) begin
                w_overflow_nxt = 1'b1;
                if (r_drop_count != L_DROP_MAX) begin
                    w_drop_count_nxt = r_drop_count + 16'd1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_overflow   <= w_overflow_nxt;
            r_drop_count <= w_drop_count_nxt;
        end
    end

    // NOTE: storage has no reset; an entry is only ever read after it has been written, and
    // gating the write with trace_val keeps don't-care bus values out of the array.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Head is forced to zero while empty so stale array contents never leak to the consumer.
    always_comb begin
        w_head = '0;
        if (!w_empty) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    assign deq_val    = !w_empty;
    assign deq_addr   = w_head.addr;
    assign deq_data   = w_head.data;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    assign deq_cycle  = w_head.cycle;
`endif

endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer: drives inputs on the falling edge, checks before the next rising edge.
module tb_trace_buffer;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             trace_val;
    logic [31:0]      trace_addr;
    logic [31:0]      trace_data;
    logic             deq_val;
    logic             deq_rdy;
    logic [31:0]      deq_addr;
    logic [31:0]      deq_data;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic [15:0]      drop_count;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    logic [31:0]      deq_cycle;
`endif

    int     checks = 0;
    int     errors = 0;
    entry_t sb[$];
    logic   m_ovf  = 1'b0;
    int     m_drop = 0;

    trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .trace_val  (trace_val),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .deq_val    (deq_val),
        .deq_rdy    (deq_rdy),
        .deq_addr   (deq_addr),
        .deq_data   (deq_data),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
`ifdef TRACE_BUFFER_TIMESTAMP_EN
        ,
        .deq_cycle  (deq_cycle)
`endif
    );

    always #5 clk = ~clk;

    // One clock cycle: drive, check pre-edge outputs against the model, update the model, advance.
    task automatic step(input logic tv, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        entry_t e;
        int     sz;
        bit     fire;
        bit     enq;
        trace_val  = tv;
        trace_addr = tv ? a : 'x;
        trace_data = tv ? d : 'x;
        deq_rdy    = rdy;
        #1;
        sz = sb.size();
        checks++;
        if (deq_val !== (sz != 0)) begin
            errors++;
            $display("FAIL deq_val: got %b expected %b", deq_val, (sz != 0));
        end
        checks++;
        if (count !== sz) begin
            errors++;
            $display("FAIL count: got %0d expected %0d", count, sz);
        end
        checks++;
        if (overflow !== m_ovf || drop_count !== m_drop) begin
            errors++;
            $display("FAIL loss_status: got ovf=%b drop=%0d expected ovf=%b drop=%0d",
                     overflow, drop_count, m_ovf, m_drop);
        end
        if (sz == 0) begin
            checks++;
            if (deq_addr !== 32'h0 || deq_data !== 32'h0) begin
                errors++;
                $display("FAIL empty_head: got %h/%h expected 0/0", deq_addr, deq_data);
            end
        end
        fire = rdy && (sz != 0);
        if (fire) begin
            e = sb.pop_front();
            checks++;
            if (deq_addr !== e.addr || deq_data !== e.data) begin
                errors++;
                $display("FAIL deq_entry: got %h/%h expected %h/%h", deq_addr, deq_data, e.addr, e.data);
            end
        end
        enq = tv && (sz < DEPTH || fire);
        if (enq) begin
            sb.push_back({a, d});
        end else if (tv) begin
            m_ovf = 1'b1;
            if (m_drop != 16'hFFFF) m_drop++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0; clear = 1'b0; trace_val = 1'b0; deq_rdy = 1'b0;
        trace_addr = '0; trace_data = '0;
        #12;
        checks++;
        if (deq_val !== 1'b0 || count !== '0 || overflow !== 1'b0 || drop_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: got val=%b cnt=%0d ovf=%b drop=%0d expected all 0",
                     deq_val, count, overflow, drop_count);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic_order();
        step(1'b1, 32'h200, 32'h6, 1'b1);
        step(1'b1, 32'h204, 32'h2A, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_fill_drop();
        for (int i = 0; i < 10; i++) step(1'b1, 32'h200 + 4 * i, 32'h1000 + i, 1'b0);
        #1;
        checks++;
        if (count !== DEPTH || overflow !== 1'b1 || drop_count !== 16'd2) begin
            errors++;
            $display("FAIL fill_drop: got cnt=%0d ovf=%b drop=%0d expected 8/1/2", count, overflow, drop_count);
        end
        drain();
    endtask

    task automatic test_full_deq();
        int drop_before;
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h400 + 4 * i, 32'h2000 + i, 1'b0);
        drop_before = m_drop;
        step(1'b1, 32'h300, 32'hABCD, 1'b1);
        checks++;
        if (count !== DEPTH || drop_count !== drop_before) begin
            errors++;
            $display("FAIL full_deq: got cnt=%0d drop=%0d expected %0d/%0d", count, drop_count, DEPTH, drop_before);
        end
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, '0, 1'b1);
        checks++;
        if (sb.size() != 1 || sb[0].addr != 32'h300) begin
            errors++;
            $display("FAIL full_deq_last: got queue size %0d expected 1 entry 0x300", sb.size());
        end
        drain();
    endtask

    task automatic test_wrap();
        int sent = 0;
        for (int cyc = 0; cyc < 200 && (sent < 20 || sb.size() != 0); cyc++) begin
            logic tv;
            logic rdy;
            tv  = (sent < 20) && (sb.size() < 5);
            rdy = (sb.size() > 2) || (sent >= 20);
            step(tv, 32'h1000 + 4 * sent, $urandom, rdy);
            if (tv) sent++;
        end
        checks++;
        if (sent != 20 || sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_budget: got sent=%0d left=%0d expected 20/0", sent, sb.size());
        end
        step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_clear();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 32'h500 + 4 * i, i, 1'b0);
        for (int i = 0; i < DEPTH - 3; i++) step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        clear = 1'b1; trace_val = 1'b1; trace_addr = 32'h600; trace_data = 32'h7; deq_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        sb.delete(); m_ovf = 1'b0; m_drop = 0;
        #1;
        checks++;
        if (count !== '0 || deq_val !== 1'b0 || overflow !== 1'b0 || drop_count !== 16'h0) begin
            errors++;
            $display("FAIL clear: got cnt=%0d val=%b ovf=%b drop=%0d expected all 0",
                     count, deq_val, overflow, drop_count);
        end
        step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h700 + 4 * i, 32'h30 + i, 1'b0);
        trace_val = 1'b0; deq_rdy = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (deq_val !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL async_reset: got val=%b cnt=%0d expected 0/0", deq_val, count);
        end
        @(negedge clk);
        rst = 1'b1;
        sb.delete(); m_ovf = 1'b0; m_drop = 0;
        step(1'b1, 32'h800, 32'h11, 1'b0);
        step(1'b1, 32'h804, 32'h22, 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_fill_drop();
        test_full_deq();
        test_wrap();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
- Captures the per-instruction commit trace (trace_val/trace_addr/trace_data) emitted by the TinyRV1 processor into a circular FIFO.
- Drains entries to a host/display consumer over a val/rdy handshake.
- Sits directly downstream of the processor trace port.
- Decouples the commit rate from a slower consumer, and records loss when the consumer falls behind.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived; do not override).

Ports:
- clk  input  1  clock.
- rst  input  1  reset. One clock; reset is asynchronous and active-low.
- clear  input  1  synchronous flush of contents and loss status.
- trace_val  input  1  processor committed an instruction this cycle.
- trace_addr  input  32  committed instruction PC.
- trace_data  input  32  committed writeback data.
- deq_val  output  1  head entry valid.
- deq_rdy  input  1  consumer accepts head this cycle.
- deq_addr  output  32  head entry PC.
- deq_data  output  32  head entry data.
- count  output  PTR_W+1  occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one trace dropped since reset/clear.
- drop_count  output  16  saturating count of dropped traces.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, deq_val=0, overflow=0, drop_count=0.
  - Storage array is not reset.
- Enqueue = trace_val && (count<DEPTH || deq fire this cycle).
  - Writes {trace_addr,trace_data} at wr_ptr.
  - wr_ptr wraps DEPTH-1 -> 0.
- Dequeue fire = deq_val && deq_rdy.
  - rd_ptr advances, wrapping DEPTH-1 -> 0.
- deq_val = (count!=0), registered-state derived.
  - deq_addr/deq_data are combinational from the entry at rd_ptr.
  - Both are forced to 0 when count==0.
- Latency and bypass:
  - An enqueued entry is visible on deq_* the cycle after capture.
  - No same-cycle bypass: empty + trace_val + deq_rdy gives deq_val=0 that cycle.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on both or neither.
- Full (count==DEPTH) with trace_val and no dequeue:
  - Trace is dropped; contents are unchanged.
  - overflow<=1.
  - drop_count<=drop_count+1, saturating at 16'hFFFF.
- Full with trace_val and a dequeue in the same cycle: trace is accepted, count stays DEPTH, no drop.
- Entries leave strictly in arrival order. Consumer stall (deq_rdy=0) holds deq_* stable.
- clear=1 at a clock edge:
  - Pointers, count, overflow and drop_count go to 0.
  - Same-cycle trace_val and deq_rdy are ignored; clear has priority.
- Reset asserted mid-stream discards all contents immediately.
- trace_val is sampled only at the rising clk edge. X on trace_addr/trace_data when trace_val=0 must not propagate into storage.

Optional Feature:
- Macro TRACE_BUFFER_TIMESTAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter is added (reset 0, wraps, not affected by clear).
  - Its value is stored with each enqueued entry.
  - New output deq_cycle [31:0] presents the head entry's stamp, 0 when empty.
- When undefined: no counter, no storage for stamps, no deq_cycle port.

Test Plan:
- Basic order: reset; enqueue (0x200,0x6) then (0x204,0x2A) on consecutive cycles, deq_rdy=1 -> deq_val rises the cycle after the first capture; deq emits 0x200/0x6 then 0x204/0x2A; count returns to 0; overflow=0.
- Fill and drop: deq_rdy=0; 10 traces with addr 0x200+4i, DEPTH=8 -> count=8, overflow=1, drop_count=2; drain yields 0x200..0x21C in order.
- Full with simultaneous deq: full buffer, trace_val=1 and deq_rdy=1 in one cycle with addr 0x300 -> count stays 8, drop_count unchanged; 0x300 emerges last.
- Pointer wrap: 20 traces interleaved with deqs keeping count in 2..5 -> every entry exits in order with matching data, across multiple pointer wraps.
- Clear priority: count=3, overflow=1, then clear=1 with trace_val=1 and deq_rdy=1 -> next cycle count=0, deq_val=0, overflow=0, drop_count=0.
- Async reset mid-stream: count=5, rst falls between edges -> deq_val=0 and count=0 immediately, before the next clk edge; after release, new traces enqueue normally.
